// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute unit: default widths, opcode
// encoding and the FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_REG_AW = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Opcodes 10..15 are unassigned.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/mul_secuencial.sv
// Sequential shift-add multiplier: low STEPS bits of the unsigned product.
// The first partial product is taken on the start edge, so done pulses STEPS-1 edges later.
module mul_secuencial #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = 6;

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= b[0] ? a : '0;
        mcand   <= a << 1;
        mplier  <= b >> 1;
        cnt     <= CNT_W'(1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(STEPS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_multiciclo.sv
// Execute stage: single-cycle ALU ops plus a sequential MUL, writing back to the
// register file through registered we/DE/Dato.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int REG_AW    = ALU_REG_AW,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  logic [REG_AW-1:0] rd,
  output logic              we,
  output logic [REG_AW-1:0] DE,
  output logic [WIDTH-1:0]  Dato,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE; in_valid seen while in_ready is low is dropped, so
  // decode must keep holding the instruction until it transfers.

  state_t            state;
  logic [REG_AW-1:0] rd_q;
  logic [WIDTH-1:0]  alu_res;
  logic [4:0]        shamt;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [WIDTH-1:0]  mul_prod;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign shamt     = op2[4:0];
  assign state_dbg = state;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $signed(op1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  mul_secuencial #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Writes to register 0 still pass through WB but never raise we or touch DE/Dato.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rd_q  <= '0;
      we    <= 1'b0;
      DE    <= '0;
      Dato  <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      we  <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
              rd_q  <= rd;
            end else if (op_legal(opcode)) begin
              state <= S_WB;
              if (rd != '0) begin
                we   <= 1'b1;
                DE   <= rd;
                Dato <= alu_res;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state <= S_WB;
            busy  <= 1'b0;
            if (rd_q != '0) begin
              we   <= 1'b1;
              DE   <= rd_q;
              Dato <= mul_prod;
            end
          end
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: expected write-backs are queued at issue time
// and a monitor pops and compares them whenever we is seen.
module tb_alu_multiciclo;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int EW = AW + W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [AW-1:0] rd;
  logic          we;
  logic [AW-1:0] DE;
  logic [W-1:0]  Dato;
  logic          busy;
  logic          err;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  alu_multiciclo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .rd        (rd),
    .we        (we),
    .DE        (DE),
    .Dato      (Dato),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: waits (bounded) for in_ready, presents one instruction for one edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    opcode   = op;
    op1      = a;
    op2      = b;
    rd       = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [AW-1:0] r, input logic [W-1:0] d);
    exp_q.push_back({r, d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we DE=%0d Dato=%0h required=no write", DE, Dato);
      end else begin
        chk("writeback", 64'({DE, Dato}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = '0;
    op1      = '0;
    op2      = '0;
    rd       = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("reset_we",       64'(we),       64'd0);
    chk("reset_DE",       64'(DE),       64'd0);
    chk("reset_Dato",     64'(Dato),     64'd0);
    chk("reset_busy",     64'(busy),     64'd0);
    chk("reset_err",      64'(err),      64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // ADD with exact timing
    expect_wb(5'd3, 32'd12);
    issue(4'd0, 32'd5, 32'd7, 5'd3);
    chk("add_we",        64'(we),       64'd1);
    chk("add_in_ready0", 64'(in_ready), 64'd0);
    tick();
    chk("add_in_ready1", 64'(in_ready), 64'd1);
    chk("add_we_drop",   64'(we),       64'd0);
    chk("add_DE_hold",   64'(DE),       64'd3);
    chk("add_Dato_hold", 64'(Dato),     64'd12);

    // single-cycle op table
    expect_wb(5'd1, 32'hFFFF_FFFE); issue(4'd1, 32'd3,          32'd5,          5'd1);
    expect_wb(5'd2, 32'hF000_F000); issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2);
    expect_wb(5'd4, 32'h0F0F_00FF); issue(4'd3, 32'h0F0F_0000, 32'h0000_00FF, 5'd4);
    expect_wb(5'd5, 32'hF0F0_0F0F); issue(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd5);
    expect_wb(5'd6, 32'd1);         issue(4'd5, 32'hFFFF_FFFF, 32'd1,          5'd6);
    expect_wb(5'd8, 32'd0);         issue(4'd5, 32'd1,          32'hFFFF_FFFF, 5'd8);
    expect_wb(5'd9, 32'hF800_0000); issue(4'd8, 32'h8000_0000, 32'h24,         5'd9);
    expect_wb(5'd10, 32'd0);        issue(4'd6, 32'h8000_0000, 32'h24,         5'd10);
    expect_wb(5'd11, 32'h0800_0000); issue(4'd7, 32'h8000_0000, 32'h24,        5'd11);
    expect_wb(5'd31, 32'd0);        issue(4'd0, 32'hFFFF_FFFF, 32'd1,          5'd31);
    tick();

    // MUL: busy for 32 cycles, offered instructions ignored, write in cycle 33
    expect_wb(5'd7, 32'h0002_0001);
    issue(4'd9, 32'h0001_0001, 32'h0001_0001, 5'd7);
    for (int i = 1; i <= 32; i++) begin
      chk("mul_busy",     64'(busy),     64'd1);
      chk("mul_in_ready", 64'(in_ready), 64'd0);
      chk("mul_no_we",    64'(we),       64'd0);
      in_valid = 1'b1;
      opcode   = 4'd0;
      op1      = 32'd1;
      op2      = 32'd1;
      rd       = 5'd12;
      tick();
    end
    in_valid = 1'b0;
    chk("mul_we",        64'(we),   64'd1);
    chk("mul_busy_done", 64'(busy), 64'd0);
    tick();
    tick();

    // rd == 0: no write, in_ready back after 2 cycles
    issue(4'd0, 32'd5, 32'd7, 5'd0);
    chk("rd0_no_we",     64'(we),       64'd0);
    chk("rd0_in_ready0", 64'(in_ready), 64'd0);
    tick();
    chk("rd0_in_ready1", 64'(in_ready), 64'd1);

    // illegal opcode
    issue(4'hF, 32'd1, 32'd2, 5'd13);
    chk("ill_err",      64'(err),      64'd1);
    chk("ill_in_ready", 64'(in_ready), 64'd1);
    chk("ill_no_we",    64'(we),       64'd0);
    tick();
    chk("ill_err_drop", 64'(err),      64'd0);

    // MUL aborted by reset at cycle 10
    issue(4'd9, 32'd3, 32'd4, 5'd14);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy",     64'(busy),     64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("abort_busy_late", 64'(busy), 64'd0);

    expect_wb(5'd15, 32'd123);
    issue(4'd0, 32'd100, 32'd23, 5'd15);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
